// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous flag FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_ADDR  = 3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Depth must be an exact power of two so pointer wrap and memory index agree.
    function automatic bit params_ok(input int depth, input int addr,
                                     input int afull_th, input int aempty_th);
        return (depth == (1 << addr)) && (clog2(depth) == addr) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers define which entries are valid,
    // and leaving it out lets the array map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy, almost-full/empty thresholds,
// optional first-word-fall-through output and sticky error flags.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR      = DEF_ADDR,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    if (!params_ok(DEPTH, ADDR, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("sync_fifo_flags: illegal DEPTH/ADDR/threshold combination");
    end

    localparam logic [ADDR:0] DEPTH_CNT  = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] AFULL_CNT  = (ADDR+1)'(AFULL_TH);
    localparam logic [ADDR:0] AEMPTY_CNT = (ADDR+1)'(AEMPTY_TH);

    logic [ADDR:0]    wptr;
    logic [ADDR:0]    rptr;
    logic [WIDTH-1:0] mem_rdata;
    logic             w_acc;
    logic             r_acc;

    // Flags decode the registered pointers directly, so they are exact every cycle.
    assign count         = wptr - rptr;
    assign wfull         = (count == DEPTH_CNT);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AFULL_CNT);
    assign ralmost_empty = (count <= AEMPTY_CNT);

    assign w_acc = winc && !wfull;
    assign r_acc = rinc && !rempty;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk   (clk),
        .we    (w_acc),
        .waddr (wptr[ADDR-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDR-1:0]),
        .rdata (mem_rdata)
    );

    // NOTE: every clocked register below uses <= so all of them sample the
    // pre-edge values, which keeps accept decisions on the old pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (w_acc) wptr <= wptr + 1'b1;
            if (r_acc) rptr <= rptr + 1'b1;
        end
    end

    // A fresh error on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (winc && wfull)  || (overflow  && !clr_err);
            underflow <= (rinc && rempty) || (underflow && !clr_err);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata = mem_rdata;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (r_acc) begin
                rdata_q <= mem_rdata;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench driving a registered-read and an FWFT build with one stimulus.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic       clr_err;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, rempty0, waf0, rae0, ovf0, unf0;
    logic       wfull1, rempty1, waf1, rae1, ovf1, unf1;
    logic [3:0] count0, count1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];

    sync_fifo_flags #(.FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
        .walmost_full(waf0), .ralmost_empty(rae0), .count(count0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    sync_fifo_flags #(.FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
        .walmost_full(waf1), .ralmost_empty(rae1), .count(count1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_fwft_head(input string tag);
        if (q.size() > 0) check(tag, rdata1, q[0]);
    endtask

    localparam logic [7:0] T1_DATA [8] = '{8'd77, 8'd79, 8'd72, 8'd65, 8'd77, 8'd77, 8'd69, 8'd68};

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = '0; rinc = 1'b0; clr_err = 1'b0;
        #3;
        check("rst_count", count0, 0);
        check("rst_rempty", rempty0, 1);
        check("rst_wfull", wfull0, 0);
        check("rst_rae", rae0, 1);
        check("rst_waf", waf0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_unf", unf0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_count_fwft", count1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fill to full, watch thresholds
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, T1_DATA[i], 1'b0, 1'b0);
            q.push_back(T1_DATA[i]);
            check($sformatf("t1_count%0d", i), count0, i + 1);
            check($sformatf("t1_waf%0d", i), waf0, (i + 1 >= 6));
            check($sformatf("t1_rae%0d", i), rae0, (i + 1 <= 2));
            check($sformatf("t1_wfull%0d", i), wfull0, (i == 7));
            check($sformatf("t1_rempty%0d", i), rempty0, 0);
            check($sformatf("t1_count_fwft%0d", i), count1, i + 1);
            check_fwft_head($sformatf("t1_fwft_head%0d", i));
        end

        // 2: write while full
        cyc(1'b1, 8'd100, 1'b0, 1'b0);
        check("t2_count", count0, 8);
        check("t2_ovf", ovf0, 1);
        check("t2_ovf_fwft", ovf1, 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        check("t2_ovf_hold", ovf0, 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check("t2_ovf_clr", ovf0, 0);
        check("t2_count_after", count0, 8);

        // 3: drain, then one extra read
        for (int i = 0; i < 8; i++) begin
            check_fwft_head($sformatf("t3_fwft_head%0d", i));
            cyc(1'b0, 8'd0, 1'b1, 1'b0);
            check($sformatf("t3_rdata%0d", i), rdata0, T1_DATA[i]);
            check($sformatf("t3_count%0d", i), count0, 7 - i);
            void'(q.pop_front());
        end
        check("t3_rempty", rempty0, 1);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        check("t3_unf", unf0, 1);
        check("t3_rdata_hold", rdata0, 68);
        check("t3_count_empty", count0, 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check("t3_unf_clr", unf0, 0);

        // 4: prefill 4, then 20 simultaneous write+read cycles (pointers wrap)
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(10 + i), 1'b0, 1'b0);
            q.push_back(8'(10 + i));
        end
        for (int i = 0; i < 20; i++) begin
            check_fwft_head($sformatf("t4_fwft_head%0d", i));
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            q.push_back(8'(i));
            check($sformatf("t4_rdata%0d", i), rdata0, (i < 4) ? 10 + i : i - 4);
            check($sformatf("t4_count%0d", i), count0, 4);
            void'(q.pop_front());
        end
        check("t4_no_err", {30'd0, ovf0, unf0}, 0);

        // 5a: drain remaining 16..19, then winc+rinc while empty
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b0);
            void'(q.pop_front());
        end
        check("t5_drained_rdata", rdata0, 19);
        check("t5_empty", rempty0, 1);
        cyc(1'b1, 8'd55, 1'b1, 1'b0);
        q.push_back(8'd55);
        check("t5e_count", count0, 1);
        check("t5e_unf", unf0, 1);
        check("t5e_rdata_nobypass", rdata0, 19);
        check_fwft_head("t5e_fwft_head");
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check("t5e_unf_clr", unf0, 0);

        // 5b: fill to full, then winc+rinc while full
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 8'(200 + i), 1'b0, 1'b0);
            q.push_back(8'(200 + i));
        end
        check("t5f_full", wfull0, 1);
        cyc(1'b1, 8'd99, 1'b1, 1'b0);
        void'(q.pop_front());
        check("t5f_count", count0, 7);
        check("t5f_ovf", ovf0, 1);
        check("t5f_rdata", rdata0, 55);
        check_fwft_head("t5f_fwft_head");

        // 6: pop to count 5 (overflow still set), then async reset between edges
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        check("t6_pre_count", count0, 5);
        check("t6_pre_ovf", ovf0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_count", count0, 0);
        check("t6_rempty", rempty0, 1);
        check("t6_ovf", ovf0, 0);
        check("t6_rdata", rdata0, 0);
        check("t6_count_fwft", count1, 0);
        check("t6_rempty_fwft", rempty1, 1);
        check("t6_ovf_fwft", ovf1, 0);
        #1;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        cyc(1'b1, 8'd42, 1'b0, 1'b0);
        check("t6_fwft_rempty", rempty1, 0);
        check("t6_fwft_rdata", rdata1, 42);
        check("t6_reg_rdata_unchanged", rdata0, 0);
        check("t6_count_after", count0, 1);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        check("t6_reg_rdata", rdata0, 42);
        check("t6_empty_again", rempty0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
